// File: rtl/ahb_ui_sequencer_if.sv
// ahb_ui_sequencer_if: command, write-data and master UI signals of the AHB UI sequencer
interface ahb_ui_sequencer_if #(
  parameter int DATA_WDT = 32,
  parameter int BEAT_WDT = 32
);
  logic                i_cmd_valid;
  logic                o_cmd_ready;
  logic [31:0]         i_cmd_addr;
  logic [BEAT_WDT-1:0] i_cmd_len;
  logic [2:0]          i_cmd_size;
  logic                i_cmd_wr;
  logic                i_wdata_valid;
  logic                o_wdata_ready;
  logic [DATA_WDT-1:0] i_wdata;
  logic                i_next;
  logic [DATA_WDT-1:0] o_data;
  logic                o_dav;
  logic [31:0]         o_addr;
  logic [2:0]          o_size;
  logic                o_wr;
  logic                o_rd;
  logic [BEAT_WDT-1:0] o_min_len;
  logic                o_cont;
  logic                o_busy;
  logic                o_done;
  modport slave (
    input  i_cmd_valid, i_cmd_addr, i_cmd_len, i_cmd_size, i_cmd_wr,
    input  i_wdata_valid, i_wdata, i_next,
    output o_cmd_ready, o_wdata_ready, o_data, o_dav, o_addr, o_size,
    output o_wr, o_rd, o_min_len, o_cont, o_busy, o_done
  );
  modport master (
    output i_cmd_valid, i_cmd_addr, i_cmd_len, i_cmd_size, i_cmd_wr,
    output i_wdata_valid, i_wdata, i_next,
    input  o_cmd_ready, o_wdata_ready, o_data, o_dav, o_addr, o_size,
    input  o_wr, o_rd, o_min_len, o_cont, o_busy, o_done
  );
endinterface

// File: rtl/ahb_ui_sequencer.sv
// ahb_ui_sequencer: turns burst commands plus a write-data FIFO into registered AHB master UI
// signals, advancing only on edges where the master raises i_next.
module ahb_ui_sequencer #(
  parameter int DATA_WDT   = 32,
  parameter int BEAT_WDT   = 32,
  parameter int FIFO_DEPTH = 4
) (
  input logic i_hclk,
  input logic i_hreset_n,
  ahb_ui_sequencer_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic {IDLE, ACTIVE} state_t;
  state_t state, state_d;
  logic [DATA_WDT-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0] count;
  logic [BEAT_WDT-1:0] rem, rem_d, min_len_d;
  logic [DATA_WDT-1:0] data_d;
  logic [31:0] addr_d;
  logic [2:0] size_d;
  logic dav_d, wr_d, rd_d, cont_d, done_d;
  logic fifo_empty, accept, start, push, pop, step, consumed, last;
  assign fifo_empty        = count == '0;
  assign bus.o_wdata_ready = count != (AW+1)'(FIFO_DEPTH);
  assign bus.o_cmd_ready   = i_hreset_n && state == IDLE && (!bus.i_cmd_wr || !fifo_empty);
  assign bus.o_busy        = state == ACTIVE;
  assign accept   = bus.i_cmd_valid && bus.o_cmd_ready;
  assign start    = accept && bus.i_cmd_len != '0;
  assign step     = state == ACTIVE && bus.i_next;
  assign consumed = step && (bus.o_rd || (bus.o_wr && bus.o_dav));
  assign last     = consumed && rem == BEAT_WDT'(1);
  assign push     = bus.i_wdata_valid && bus.o_wdata_ready;
  // a starved write beat retries the FIFO head on every i_next edge until data arrives
  assign pop      = (start && bus.i_cmd_wr) || (step && bus.o_wr && !last && !fifo_empty);
  always_ff @(posedge i_hclk or negedge i_hreset_n)
    if (!i_hreset_n) state <= IDLE;
    else state <= state_d;
  always_comb state_d = state == IDLE ? (start ? ACTIVE : IDLE) : (last ? IDLE : ACTIVE);
  always_comb begin
    rem_d     = rem;
    data_d    = bus.o_data;
    dav_d     = bus.o_dav;
    addr_d    = bus.o_addr;
    size_d    = bus.o_size;
    min_len_d = bus.o_min_len;
    wr_d      = bus.o_wr;
    rd_d      = bus.o_rd;
    cont_d    = bus.o_cont;
    done_d    = (accept && !start) || last;
    if (start) begin
      addr_d    = bus.i_cmd_addr;
      size_d    = bus.i_cmd_size;
      min_len_d = bus.i_cmd_len;
      rem_d     = bus.i_cmd_len;
      cont_d    = 1'b0;
      rd_d      = !bus.i_cmd_wr;
      wr_d      = bus.i_cmd_wr;
      dav_d     = bus.i_cmd_wr;
      data_d    = bus.i_cmd_wr ? mem[rptr] : bus.o_data;
    end else if (step) begin
      rem_d  = consumed ? rem - BEAT_WDT'(1) : rem;
      cont_d = consumed || bus.o_cont;
      if (last) begin
        rd_d   = 1'b0;
        wr_d   = 1'b0;
        dav_d  = 1'b0;
        cont_d = 1'b0;
      end else if (bus.o_wr) begin
        dav_d  = !fifo_empty;
        data_d = fifo_empty ? bus.o_data : mem[rptr];
      end
    end
  end
  always_ff @(posedge i_hclk or negedge i_hreset_n)
    if (!i_hreset_n) begin
      rem           <= '0;
      bus.o_data    <= '0;
      bus.o_dav     <= 1'b0;
      bus.o_addr    <= '0;
      bus.o_size    <= '0;
      bus.o_min_len <= '0;
      bus.o_wr      <= 1'b0;
      bus.o_rd      <= 1'b0;
      bus.o_cont    <= 1'b0;
      bus.o_done    <= 1'b0;
      wptr          <= '0;
      rptr          <= '0;
      count         <= '0;
    end else begin
      rem           <= rem_d;
      bus.o_data    <= data_d;
      bus.o_dav     <= dav_d;
      bus.o_addr    <= addr_d;
      bus.o_size    <= size_d;
      bus.o_min_len <= min_len_d;
      bus.o_wr      <= wr_d;
      bus.o_rd      <= rd_d;
      bus.o_cont    <= cont_d;
      bus.o_done    <= done_d;
      wptr          <= push ? wptr + AW'(1) : wptr;
      rptr          <= pop ? rptr + AW'(1) : rptr;
      count         <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  always_ff @(posedge i_hclk)
    if (push) mem[wptr] <= bus.i_wdata;
endmodule

// File: tb/tb_ahb_ui_sequencer.sv
// tb_ahb_ui_sequencer: directed stimulus with a scoreboard of expected UI beats and done pulses,
// popped by a monitor at every consumed beat or o_done.
module tb_ahb_ui_sequencer;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  ahb_ui_sequencer_if #(.DATA_WDT(32), .BEAT_WDT(32)) bus ();
  ahb_ui_sequencer #(.DATA_WDT(32), .BEAT_WDT(32), .FIFO_DEPTH(4)) dut (
    .i_hclk(clk), .i_hreset_n(rst_n), .bus(bus)
  );
  typedef struct packed {
    logic        is_done;
    logic        wr;
    logic [31:0] data;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [31:0] min_len;
    logic        cont;
  } ev_t;
  ev_t exp_q[$];
  ev_t mon_ev;
  int total = 0;
  int bad = 0;
  function automatic void check(string name, logic [63:0] act, logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endfunction
  function automatic void sb_cmp(ev_t got);
    ev_t want;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $display("FAIL scoreboard unexpected event at %0t: got %h", $time, got);
    end else begin
      want = exp_q.pop_front();
      if (got !== want) begin
        bad++;
        $display("FAIL scoreboard at %0t: got %h want %h", $time, got, want);
      end
    end
  endfunction
  task automatic exp_beat(logic wr, logic [31:0] data, logic [31:0] addr, logic [2:0] size,
                          logic [31:0] len, logic cont);
    ev_t e;
    e.is_done = 1'b0;
    e.wr      = wr;
    e.data    = wr ? data : 32'h0;
    e.addr    = addr;
    e.size    = size;
    e.min_len = len;
    e.cont    = cont;
    exp_q.push_back(e);
  endtask
  task automatic exp_done();
    ev_t e = '0;
    e.is_done = 1'b1;
    exp_q.push_back(e);
  endtask
  always @(negedge clk) if (rst_n) begin
    if (bus.o_done) begin
      mon_ev = '0;
      mon_ev.is_done = 1'b1;
      sb_cmp(mon_ev);
    end
    if (bus.i_next && (bus.o_rd || (bus.o_wr && bus.o_dav))) begin
      mon_ev.is_done = 1'b0;
      mon_ev.wr      = bus.o_wr;
      mon_ev.data    = bus.o_wr ? bus.o_data : 32'h0;
      mon_ev.addr    = bus.o_addr;
      mon_ev.size    = bus.o_size;
      mon_ev.min_len = bus.o_min_len;
      mon_ev.cont    = bus.o_cont;
      sb_cmp(mon_ev);
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic push_word(logic [31:0] d);
    bus.i_wdata = d;
    bus.i_wdata_valid = 1'b1;
    tick();
    bus.i_wdata_valid = 1'b0;
  endtask
  task automatic send_cmd(logic [31:0] addr, logic [31:0] len, logic [2:0] size, logic wr);
    bit ok = 1'b0;
    bus.i_cmd_addr = addr;
    bus.i_cmd_len = len;
    bus.i_cmd_size = size;
    bus.i_cmd_wr = wr;
    bus.i_cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = bus.o_cmd_ready;
      tick();
    end
    bus.i_cmd_valid = 1'b0;
    check("cmd_accepted", 64'(ok), 64'd1);
  endtask
  task automatic wait_idle(string name);
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      ok = !bus.o_busy;
    end
    check(name, 64'(ok), 64'd1);
    tick();
    tick();
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
  initial begin
    bus.i_cmd_valid = 1'b0;
    bus.i_cmd_addr = '0;
    bus.i_cmd_len = '0;
    bus.i_cmd_size = '0;
    bus.i_cmd_wr = 1'b0;
    bus.i_wdata_valid = 1'b0;
    bus.i_wdata = '0;
    bus.i_next = 1'b1;
    #12;
    check("rst cmd_ready", 64'(bus.o_cmd_ready), 64'd0);
    check("rst wdata_ready", 64'(bus.o_wdata_ready), 64'd1);
    check("rst flags", 64'({bus.o_rd, bus.o_wr, bus.o_dav, bus.o_cont, bus.o_busy, bus.o_done}), 64'd0);
    check("rst data", 64'(bus.o_data), 64'd0);
    check("rst addr", 64'(bus.o_addr), 64'd0);
    check("rst size_len", 64'({bus.o_size, bus.o_min_len}), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    // read burst of four with i_next held high
    for (int i = 0; i < 4; i++) exp_beat(1'b0, 32'h0, 32'h1000, 3'd2, 32'd4, i != 0);
    exp_done();
    send_cmd(32'h1000, 32'd4, 3'd2, 1'b0);
    check("rd4 busy", 64'(bus.o_busy), 64'd1);
    check("rd4 rd", 64'(bus.o_rd), 64'd1);
    wait_idle("rd4 idle");
    check("rd4 rd after", 64'(bus.o_rd), 64'd0);
    // write of three preloaded words with a stall on the second beat
    push_word(32'hA0A0_0001);
    push_word(32'hB0B0_0002);
    push_word(32'hC0C0_0003);
    exp_beat(1'b1, 32'hA0A0_0001, 32'h2000, 3'd2, 32'd3, 1'b0);
    exp_beat(1'b1, 32'hB0B0_0002, 32'h2000, 3'd2, 32'd3, 1'b1);
    exp_beat(1'b1, 32'hC0C0_0003, 32'h2000, 3'd2, 32'd3, 1'b1);
    exp_done();
    send_cmd(32'h2000, 32'd3, 3'd2, 1'b1);
    check("wr3 first data", 64'(bus.o_data), 64'hA0A0_0001);
    tick();
    bus.i_next = 1'b0;
    check("wr3 stall data", 64'(bus.o_data), 64'hB0B0_0002);
    tick();
    check("wr3 stall hold", 64'(bus.o_data), 64'hB0B0_0002);
    check("wr3 stall cont", 64'(bus.o_cont), 64'd1);
    bus.i_next = 1'b1;
    wait_idle("wr3 idle");
    #1;
    check("wr3 fifo empty", 64'(bus.o_cmd_ready), 64'd0);
    // write of three with only two words available up front
    push_word(32'h1111_0001);
    push_word(32'h2222_0002);
    exp_beat(1'b1, 32'h1111_0001, 32'h2100, 3'd1, 32'd3, 1'b0);
    exp_beat(1'b1, 32'h2222_0002, 32'h2100, 3'd1, 32'd3, 1'b1);
    exp_beat(1'b1, 32'h3333_0003, 32'h2100, 3'd1, 32'd3, 1'b1);
    exp_done();
    send_cmd(32'h2100, 32'd3, 3'd1, 1'b1);
    tick();
    tick();
    check("starve dav", 64'(bus.o_dav), 64'd0);
    check("starve wr", 64'(bus.o_wr), 64'd1);
    repeat (3) tick();
    check("starve hold", 64'({bus.o_dav, bus.o_busy, bus.o_done}), 64'b010);
    push_word(32'h3333_0003);
    wait_idle("starve idle");
    // overfill the FIFO with five pushes and no command
    for (int i = 0; i < 5; i++) begin
      check($sformatf("fill ready %0d", i), 64'(bus.o_wdata_ready), (i < 4) ? 64'd1 : 64'd0);
      push_word(32'hC000_0001 + 32'(i));
    end
    check("full ready", 64'(bus.o_wdata_ready), 64'd0);
    exp_beat(1'b1, 32'hC000_0001, 32'h2200, 3'd2, 32'd2, 1'b0);
    exp_beat(1'b1, 32'hC000_0002, 32'h2200, 3'd2, 32'd2, 1'b1);
    exp_done();
    send_cmd(32'h2200, 32'd2, 3'd2, 1'b1);
    wait_idle("fill wr2 idle");
    check("two left ready", 64'(bus.o_wdata_ready), 64'd1);
    exp_beat(1'b1, 32'hC000_0003, 32'h2300, 3'd2, 32'd2, 1'b0);
    exp_beat(1'b1, 32'hC000_0004, 32'h2300, 3'd2, 32'd2, 1'b1);
    exp_done();
    send_cmd(32'h2300, 32'd2, 3'd2, 1'b1);
    wait_idle("leftover idle");
    #1;
    check("fifth dropped", 64'(bus.o_cmd_ready), 64'd0);
    // zero-length command
    exp_done();
    send_cmd(32'h2400, 32'd0, 3'd2, 1'b0);
    check("len0 done", 64'(bus.o_done), 64'd1);
    check("len0 quiet", 64'({bus.o_rd, bus.o_wr, bus.o_busy}), 64'd0);
    tick();
    check("len0 done once", 64'(bus.o_done), 64'd0);
    // reset in the middle of a read burst once rem has reached 5
    for (int i = 0; i < 3; i++) exp_beat(1'b0, 32'h0, 32'h3000, 3'd2, 32'd8, i != 0);
    send_cmd(32'h3000, 32'd8, 3'd2, 1'b0);
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    check("midrst flags", 64'({bus.o_rd, bus.o_wr, bus.o_dav, bus.o_cont, bus.o_busy, bus.o_done}), 64'd0);
    check("midrst addr_len", 64'({bus.o_addr, bus.o_min_len}), 64'd0);
    check("midrst ready", 64'({bus.o_cmd_ready, bus.o_wdata_ready}), 64'b01);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    exp_beat(1'b0, 32'h0, 32'h4000, 3'd0, 32'd1, 1'b0);
    exp_done();
    send_cmd(32'h4000, 32'd1, 3'd0, 1'b0);
    check("post rst cont", 64'(bus.o_cont), 64'd0);
    wait_idle("post rst idle");
    repeat (3) tick();
    check("scoreboard drained", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ahb_ui_sequencer.md
AHB_UI_SEQUENCER -- requirements
Module: ahb_ui_sequencer

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning.
- DATA_WDT, 32, data width; equals the AHB master DATA_WDT.
- BEAT_WDT, 32, burst length width; equals the AHB master BEAT_WDT.
- FIFO_DEPTH, 4, write-data FIFO entries; power of 2, at least 2.

REQ-002 SHALL have ports, one per line: name, direction, width, meaning. Single clock i_hclk; reset i_hreset_n is asynchronous, active-low.
- i_hclk, in, 1, AHB clock.
- i_hreset_n, in, 1, async active-low reset.
- i_cmd_valid, in, 1, command valid.
- o_cmd_ready, out, 1, command accepted this edge when both valid and ready are 1.
- i_cmd_addr, in, 32, burst base address.
- i_cmd_len, in, BEAT_WDT, beat count.
- i_cmd_size, in, 3, hsize encoding.
- i_cmd_wr, in, 1, 1 = write, 0 = read.
- i_wdata_valid, in, 1, write-data push request.
- o_wdata_ready, out, 1, FIFO not full.
- i_wdata, in, DATA_WDT, write data.
- i_next, in, 1, master next indication; master samples UI at edges where it is 1.
- o_data, out, DATA_WDT, UI write data.
- o_dav, out, 1, UI data valid.
- o_addr, out, 32, UI base address.
- o_size, out, 3, UI size.
- o_wr, out, 1, UI write.
- o_rd, out, 1, UI read.
- o_min_len, out, BEAT_WDT, UI min length.
- o_cont, out, 1, UI continue.
- o_busy, out, 1, state is ACTIVE.
- o_done, out, 1, one-cycle pulse when a command completes.

Function
REQ-003 SHALL use two states, IDLE and ACTIVE, plus a beat counter rem of BEAT_WDT bits (beats not yet consumed).
REQ-004 SHALL drive all UI outputs from registers. In ACTIVE they update only at edges where i_next=1.
REQ-005 SHALL drive o_cmd_ready=1 only in IDLE, and for a write command only when the FIFO is non-empty.
REQ-006 SHALL, on command accept with i_cmd_len=0, remain in IDLE, pulse o_done the next cycle, and generate no UI activity.
REQ-007 SHALL, on command accept with len>0, in the next cycle:
- enter ACTIVE;
- set o_addr, o_size and o_min_len from the command, o_cont=0, rem=len;
- set o_rd=!wr and o_wr=wr;
- for a write, load o_data from the FIFO head, pop it, and set o_dav=1;
- for a read, set o_dav=0.
REQ-008 SHALL count a beat as consumed at an ACTIVE edge with i_next=1 and (o_rd=1, or o_wr=1 and o_dav=1).
REQ-009 SHALL, on a consumed beat, decrement rem and set o_cont=1.
REQ-010 SHALL, when rem reaches 0 on a consumed beat, at that same edge:
- go IDLE;
- clear o_rd, o_wr, o_dav and o_cont;
- pulse o_done the following cycle.
REQ-011 SHALL, at an ACTIVE write edge with i_next=1 that does not end the burst, reload the data registers:
- FIFO non-empty: o_data = head, pop, o_dav=1;
- FIFO empty: o_dav=0 (the master inserts BUSY, and rem does not change).
REQ-012 SHALL hold all UI outputs unchanged at edges where i_next=0, regardless of FIFO changes.
REQ-013 SHALL hold o_addr and o_min_len constant while o_cont=1.
REQ-014 SHALL push i_wdata when i_wdata_valid and o_wdata_ready.
- Full with a simultaneous pop: no push, because ready is 0.
- Empty with a simultaneous push: the push lands and no pop occurs that edge.
REQ-015 SHALL retain FIFO words beyond the current command's length for the next command.
REQ-016 SHALL use modulo-FIFO_DEPTH pointer wrap with an occupancy counter of log2(FIFO_DEPTH)+1 bits.
REQ-017 SHALL never underflow rem. A consumed beat with rem=1 is the terminal beat.

Reset
REQ-018 SHALL, on i_hreset_n=0, asynchronously set the state to IDLE and empty the FIFO.
REQ-019 SHALL, on reset, clear o_rd, o_wr, o_dav, o_cont, o_busy, o_done and rem to 0, and set o_cmd_ready=0 and o_wdata_ready=1.
REQ-020 SHALL abandon a burst in progress on reset mid-burst, with no o_done pulse.
REQ-021 SHALL leave o_data, o_addr, o_size and o_min_len at 0 after reset.

Verification
REQ-022 Read, len=4, i_next held 1 -> o_rd=1 for exactly 4 edges; o_cont 0,1,1,1; o_done pulses once; o_busy falls after the 4th beat.
REQ-023 Write, len=3, FIFO preloaded with A,B,C; i_next=0 on the 2nd cycle -> o_data sequence A,B,C with B held through the stall edge; FIFO empty afterwards.
REQ-024 Write, len=3, only A,B pushed -> after B is consumed o_dav=0 and o_wr=1; rem stays 1 until C is pushed; then C is consumed and o_done pulses.
REQ-025 Push 5 words with FIFO_DEPTH=4 and no command -> o_wdata_ready=0 after the 4th push; the 5th word is not stored; a len=2 write consumes words 1-2 and leaves 2 words.
REQ-026 Command len=0 -> o_done pulse one cycle later; o_rd and o_wr never asserted.
REQ-027 Reset asserted mid read burst (rem=5) -> all outputs at reset values immediately; no o_done; the next command starts with o_cont=0.
